prll_bs_drvr_fifo: RTL and testbench

Driver-side endpoint of the parallel bus generator/arbiter. It holds one transmit FIFO that the host fills and the bus drains through `pndng`/`pop`/`D_pop`. It also holds one receive FIFO that the bus fills through `push`/`D_push` and the host drains. One instance sits at each `[bus][drvr]` port of the arbiter. It also provides destination filtering and sticky error reporting.

---
 rtl/prll_bs_drvr_fifo_if.sv | 34 +++
 rtl/prll_bs_drvr_fifo.sv | 92 +++++++++
 tb/tb_prll_bs_drvr_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/prll_bs_drvr_fifo_if.sv
// Handshake and data bundle between the arbiter/host side and one driver FIFO endpoint.
// master drives requests and data; slave is the FIFO endpoint itself.
interface prll_bs_drvr_fifo_if #(
   parameter int unsigned bits  = 32,
   parameter int unsigned depth = 16
);
   localparam int unsigned cw = $clog2(depth) + 1;

   logic            tx_vld;
   logic            tx_rdy;
   logic [bits-1:0] tx_data;
   logic            pndng;
   logic            pop;
   logic [bits-1:0] D_pop;
   logic            push;
   logic [bits-1:0] D_push;
   logic            rx_vld;
   logic            rx_rdy;
   logic [bits-1:0] rx_data;
   logic [cw-1:0]   tx_cnt;
   logic [cw-1:0]   rx_cnt;
   logic [2:0]      err;
   logic            err_clr;

   modport master (
      output tx_vld, tx_data, pop, push, D_push, rx_rdy, err_clr,
      input  tx_rdy, pndng, D_pop, rx_vld, rx_data, tx_cnt, rx_cnt, err
   );

   modport slave (
      input  tx_vld, tx_data, pop, push, D_push, rx_rdy, err_clr,
      output tx_rdy, pndng, D_pop, rx_vld, rx_data, tx_cnt, rx_cnt, err
   );
endinterface

// File: rtl/prll_bs_drvr_fifo.sv
// Driver-side endpoint: host-filled tx FIFO drained by the arbiter, arbiter-filled rx FIFO
// drained by the host, with destination filtering and sticky error flags.
module prll_bs_drvr_fifo #(
   parameter int unsigned bits      = 32,
   parameter int unsigned depth     = 16,
   parameter logic [7:0]  id        = 8'd0,
   parameter logic [7:0]  broadcast = {8{1'b1}}
) (
   input logic                   clk,
   input logic                   reset,
   prll_bs_drvr_fifo_if.slave    bus
);
   localparam int unsigned aw = $clog2(depth);
   localparam int unsigned cw = aw + 1;
   localparam logic [cw-1:0] full = cw'(depth);

   logic [bits-1:0] tx_mem [depth];
   logic [bits-1:0] rx_mem [depth];
   logic [aw-1:0]   tx_wr_ptr, tx_rd_ptr;
   logic [aw-1:0]   rx_wr_ptr, rx_rd_ptr;
   logic [cw-1:0]   tx_count, tx_count_d;
   logic [cw-1:0]   rx_count, rx_count_d;
   logic [2:0]      err_q;

   logic       tx_wr, tx_rd, rx_wr, rx_rd;
   logic       dst_match;
   logic [2:0] err_evt;

   // Flags come from registered counts only; a write while full is still taken when a pop
   // frees the slot on the same edge so the stream keeps 1 packet/cycle.
   always_comb begin
      tx_rd     = bus.pop && (tx_count != '0);
      tx_wr     = bus.tx_vld && ((tx_count != full) || tx_rd);
      rx_rd     = bus.rx_rdy && (rx_count != '0);
      dst_match = (bus.D_push[bits-1 -: 8] == id) || (bus.D_push[bits-1 -: 8] == broadcast);
      rx_wr     = bus.push && dst_match && ((rx_count != full) || rx_rd);
      err_evt   = {bus.push && !dst_match,
                   bus.pop && (tx_count == '0),
                   bus.push && dst_match && !rx_wr};
   end

   always_comb begin
      tx_count_d = tx_count;
      case ({tx_wr, tx_rd})
         2'b10:   tx_count_d = tx_count + cw'(1);
         2'b01:   tx_count_d = tx_count - cw'(1);
         default: tx_count_d = tx_count;
      endcase
      rx_count_d = rx_count;
      case ({rx_wr, rx_rd})
         2'b10:   rx_count_d = rx_count + cw'(1);
         2'b01:   rx_count_d = rx_count - cw'(1);
         default: rx_count_d = rx_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         tx_count  <= '0;
         rx_count  <= '0;
         err_q     <= 3'b000;
      end else begin
         if (tx_wr) begin
            tx_mem[tx_wr_ptr] <= bus.tx_data;
            tx_wr_ptr         <= tx_wr_ptr + aw'(1);
         end
         if (tx_rd) tx_rd_ptr <= tx_rd_ptr + aw'(1);
         if (rx_wr) begin
            rx_mem[rx_wr_ptr] <= bus.D_push;
            rx_wr_ptr         <= rx_wr_ptr + aw'(1);
         end
         if (rx_rd) rx_rd_ptr <= rx_rd_ptr + aw'(1);
         tx_count <= tx_count_d;
         rx_count <= rx_count_d;
         // A new event outranks a clear on the same edge.
         err_q    <= (bus.err_clr ? 3'b000 : err_q) | err_evt;
      end
   end

   assign bus.tx_rdy  = (tx_count != full);
   assign bus.pndng   = (tx_count != '0);
   assign bus.D_pop   = tx_mem[tx_rd_ptr];
   assign bus.rx_vld  = (rx_count != '0);
   assign bus.rx_data = rx_mem[rx_rd_ptr];
   assign bus.tx_cnt  = tx_count;
   assign bus.rx_cnt  = rx_count;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_prll_bs_drvr_fifo.sv
// Scoreboard bench: a queue-based reference model updates on each edge, a monitor compares
// the DUT's flags and presented heads against it, and directed steps add fixed checks.
module tb_prll_bs_drvr_fifo;
   localparam int unsigned BITS  = 32;
   localparam int unsigned DEPTH = 16;
   localparam logic [7:0]  ID    = 8'h03;
   localparam logic [7:0]  BCAST = 8'hFF;

   logic clk = 1'b0;
   logic reset;
   logic mon_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   prll_bs_drvr_fifo_if #(.bits(BITS), .depth(DEPTH)) bus ();

   prll_bs_drvr_fifo #(
      .bits(BITS), .depth(DEPTH), .id(ID), .broadcast(BCAST)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: plain queues following the FIFO and filtering rules.
   logic [BITS-1:0] tx_q[$];
   logic [BITS-1:0] rx_q[$];
   logic [2:0]      m_err = 3'b000;

   always @(posedge clk) begin : model
      logic       pop_ok, rd_ok, match;
      logic [2:0] ev;
      if (reset) begin
         tx_q.delete();
         rx_q.delete();
         m_err = 3'b000;
      end else begin
         ev     = 3'b000;
         pop_ok = bus.pop && (tx_q.size() > 0);
         if (bus.pop && !pop_ok) ev[1] = 1'b1;
         if (pop_ok) void'(tx_q.pop_front());
         if (bus.tx_vld && tx_q.size() < DEPTH) tx_q.push_back(bus.tx_data);
         rd_ok = bus.rx_rdy && (rx_q.size() > 0);
         if (rd_ok) void'(rx_q.pop_front());
         match = (bus.D_push[31:24] == ID) || (bus.D_push[31:24] == BCAST);
         if (bus.push) begin
            if (!match) ev[2] = 1'b1;
            else if (rx_q.size() < DEPTH) rx_q.push_back(bus.D_push);
            else ev[0] = 1'b1;
         end
         m_err = (bus.err_clr ? 3'b000 : m_err) | ev;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("tx_rdy", 64'(bus.tx_rdy), 64'(tx_q.size() != DEPTH));
         check("pndng", 64'(bus.pndng), 64'(tx_q.size() != 0));
         check("rx_vld", 64'(bus.rx_vld), 64'(rx_q.size() != 0));
         check("tx_cnt", 64'(bus.tx_cnt), 64'(tx_q.size()));
         check("rx_cnt", 64'(bus.rx_cnt), 64'(rx_q.size()));
         check("err", 64'(bus.err), 64'(m_err));
         if (tx_q.size() > 0) check("D_pop", 64'(bus.D_pop), 64'(tx_q[0]));
         if (rx_q.size() > 0) check("rx_data", 64'(bus.rx_data), 64'(rx_q[0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.tx_vld  = 1'b0;
      bus.tx_data = '0;
      bus.pop     = 1'b0;
      bus.push    = 1'b0;
      bus.D_push  = '0;
      bus.rx_rdy  = 1'b0;
      bus.err_clr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with arbitrary inputs active.
      reset       = 1'b1;
      bus.tx_vld  = 1'b1;
      bus.tx_data = $urandom;
      bus.pop     = 1'b1;
      bus.push    = 1'b1;
      bus.D_push  = {ID, 24'h123456};
      bus.rx_rdy  = 1'b1;
      bus.err_clr = 1'b0;
      tick();
      mon_en = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      check("reset_tx_rdy", 64'(bus.tx_rdy), 64'd1);
      check("reset_err", 64'(bus.err), 64'd0);
      tick();

      // Fill 16, refuse the 17th, drain in order.
      for (int i = 1; i <= 17; i++) begin
         bus.tx_vld  = 1'b1;
         bus.tx_data = 32'(i);
         tick();
      end
      idle();
      check("fill_cnt", 64'(bus.tx_cnt), 64'd16);
      check("fill_rdy", 64'(bus.tx_rdy), 64'd0);
      check("fill_head", 64'(bus.D_pop), 64'h1);
      bus.pop = 1'b1;
      repeat (16) tick();
      idle();
      check("drain_pndng", 64'(bus.pndng), 64'd0);

      // Full FIFO with simultaneous write and pop.
      for (int i = 0; i < 16; i++) begin
         bus.tx_vld  = 1'b1;
         bus.tx_data = 32'h100 + 32'(i);
         tick();
      end
      bus.pop = 1'b1;
      for (int i = 16; i < 36; i++) begin
         bus.tx_data = 32'h100 + 32'(i);
         tick();
      end
      check("full_ops_cnt", 64'(bus.tx_cnt), 64'd16);
      check("full_ops_head", 64'(bus.D_pop), 64'h114);
      bus.tx_vld = 1'b0;
      repeat (16) tick();
      idle();

      // Destination filter.
      bus.push   = 1'b1;
      bus.D_push = 32'h0300_00AA;
      tick();
      bus.D_push = 32'hFF00_00BB;
      tick();
      bus.D_push = 32'h0500_00CC;
      tick();
      idle();
      check("filter_err", 64'(bus.err), 64'b100);
      check("filter_cnt", 64'(bus.rx_cnt), 64'd2);
      check("filter_first", 64'(bus.rx_data), 64'h0300_00AA);
      bus.rx_rdy = 1'b1;
      tick();
      check("filter_second", 64'(bus.rx_data), 64'hFF00_00BB);
      tick();
      idle();
      bus.err_clr = 1'b1;
      tick();
      idle();

      // Receive overflow.
      for (int i = 1; i <= 17; i++) begin
         bus.push   = 1'b1;
         bus.D_push = 32'h0300_0000 + 32'(i);
         tick();
      end
      idle();
      check("ovf_cnt", 64'(bus.rx_cnt), 64'd16);
      check("ovf_err0", 64'(bus.err[0]), 64'd1);
      bus.rx_rdy = 1'b1;
      repeat (16) tick();
      idle();
      check("ovf_drained", 64'(bus.rx_vld), 64'd0);
      bus.err_clr = 1'b1;
      tick();
      idle();

      // Pop while empty, clear, then reset mid-operation.
      bus.pop = 1'b1;
      tick();
      idle();
      check("empty_pop_err1", 64'(bus.err[1]), 64'd1);
      bus.err_clr = 1'b1;
      tick();
      idle();
      check("err_cleared", 64'(bus.err), 64'd0);
      for (int i = 0; i < 5; i++) begin
         bus.tx_vld  = 1'b1;
         bus.tx_data = 32'hA0 + 32'(i);
         tick();
      end
      idle();
      check("pre_reset_cnt", 64'(bus.tx_cnt), 64'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_reset_pndng", 64'(bus.pndng), 64'd0);
      check("mid_reset_cnt", 64'(bus.tx_cnt), 64'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         logic [7:0] dst;
         bus.tx_vld  = 1'($urandom_range(0, 1));
         bus.tx_data = $urandom;
         bus.pop     = ($urandom_range(0, 99) < 45);
         bus.push    = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       dst = BCAST;
            1:       dst = 8'($urandom);
            default: dst = ID;
         endcase
         bus.D_push  = {dst, 24'($urandom)};
         bus.rx_rdy  = ($urandom_range(0, 99) < 40);
         bus.err_clr = ($urandom_range(0, 99) < 5);
         reset       = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
